// File: rtl/data_mem_lsu_pipe.sv
// Pipelined load/store unit: registered memory request stage, byte-lane alignment,
// in-order load metadata tracking with sign/zero extension and misalignment rejection.
module data_mem_lsu_pipe #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_wr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic              req_zero_extnd_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [3:0]        mem_wstrb_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_rsp_valid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o,
  output logic              spurious_rsp_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [1:0] offset;
    logic [1:0] size;
    logic       zext;
  } meta_t;

  meta_t             meta_mem [MAX_OUTSTANDING];
  meta_t             head_meta;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              fifo_full;
  logic              req_accept;
  logic              req_legal;
  logic              push;
  logic              pop;
  logic [3:0]        wstrb_next;
  logic [31:0]       wdata_next;
  logic [31:0]       rdata_shifted;
  logic [31:0]       rdata_next;

  // Full is taken from the registered count only; a pop in the same cycle does not reopen ready.
  assign fifo_full   = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign req_ready_o = (!mem_req_valid_o | mem_req_ready_i) & !fifo_full;
  assign req_accept  = req_valid_i & req_ready_o;
  assign push        = req_accept & req_legal & !req_wr_i;
  assign pop         = mem_rsp_valid_i & (count_reg != '0);
  assign head_meta   = meta_mem[rd_ptr_reg];

  always_comb begin
    req_legal  = 1'b0;
    wstrb_next = 4'b0000;
    case (req_size_i)
      SIZE_BYTE: begin
        req_legal  = 1'b1;
        wstrb_next = 4'b0001 << req_addr_i[1:0];
      end
      SIZE_HALF: begin
        req_legal  = !req_addr_i[0];
        wstrb_next = 4'b0011 << req_addr_i[1:0];
      end
      SIZE_WORD: begin
        req_legal  = (req_addr_i[1:0] == 2'b00);
        wstrb_next = 4'hF;
      end
      default: ;
    endcase
  end

  // Replicate store data so whichever lanes the strobe enables carry the right bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
    assign wdata_next[8*gi +: 8] =
      (req_size_i == SIZE_BYTE) ? req_wdata_i[7:0] :
      (req_size_i == SIZE_HALF) ? req_wdata_i[8*(gi%2) +: 8] :
                                  req_wdata_i[8*gi +: 8];
  end

  assign rdata_shifted = mem_rdata_i >> {head_meta.offset, 3'b000};

  always_comb begin
    rdata_next = rdata_shifted;
    case (head_meta.size)
      SIZE_BYTE: rdata_next = head_meta.zext ? {24'd0, rdata_shifted[7:0]}
                                             : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      SIZE_HALF: rdata_next = head_meta.zext ? {16'd0, rdata_shifted[15:0]}
                                             : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default:   rdata_next = rdata_shifted;
    endcase
  end

  // Metadata storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      meta_mem[wr_ptr_reg] <= '{offset: req_addr_i[1:0], size: req_size_i, zext: req_zero_extnd_i};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      mem_wr_o        <= 1'b0;
      mem_wstrb_o     <= 4'b0000;
      mem_wdata_o     <= '0;
      rsp_valid_o     <= 1'b0;
      rsp_rdata_o     <= '0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
      spurious_rsp_o  <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      if (req_accept && req_legal) begin
        mem_req_valid_o <= 1'b1;
        mem_addr_o      <= {req_addr_i[ADDR_W-1:2], 2'b00};
        mem_wr_o        <= req_wr_i;
        mem_wstrb_o     <= req_wr_i ? wstrb_next : 4'b0000;
        mem_wdata_o     <= req_wr_i ? wdata_next : 32'd0;
      end else if (mem_req_ready_i) begin
        mem_req_valid_o <= 1'b0;
      end

      misalign_o <= req_accept & !req_legal;
      if (req_accept && !req_legal) begin
        misalign_addr_o <= req_addr_i;
      end

      rsp_valid_o    <= pop;
      spurious_rsp_o <= mem_rsp_valid_i & !pop;
      if (pop) begin
        rsp_rdata_o <= rdata_next;
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu_pipe.sv
// Directed bench for data_mem_lsu_pipe: each task drives one scenario and checks
// hand-computed results inline.
module tb_data_mem_lsu_pipe;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic        req_wr_i;
  logic [31:0] req_wdata_i;
  logic        req_zero_extnd_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_wr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
  logic        spurious_rsp_o;

  int errors = 0;
  int checks = 0;

  data_mem_lsu_pipe #(.MAX_OUTSTANDING(4), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_wr_i(req_wr_i), .req_wdata_i(req_wdata_i),
    .req_zero_extnd_i(req_zero_extnd_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_wdata_o(mem_wdata_o), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .misalign_o(misalign_o),
    .misalign_addr_o(misalign_addr_o), .spurious_rsp_o(spurious_rsp_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [1:0] s,
                         input logic wr, input logic [31:0] d, input logic z);
    req_valid_i = v; req_addr_i = a; req_size_i = s;
    req_wr_i = wr; req_wdata_i = d; req_zero_extnd_i = z;
    if (v) $display("txn: %s size=%0d addr=%h wdata=%h zext=%0b", wr ? "ST" : "LD", s, a, d, z);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rdata_i = '0;
    set_req(1'b0, '0, SZ_W, 1'b0, '0, 1'b0);
    tick(); tick();
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid_o); end
    checks++; if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_rsp: got %b/%h want 0/0", rsp_valid_o, rsp_rdata_o); end
    checks++; if (misalign_o !== 1'b0 || misalign_addr_o !== 32'd0 || spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%h/%b want 0/0/0", misalign_o, misalign_addr_o, spurious_rsp_o); end
    reset_n = 1'b1;
    tick();
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_spurious();
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    $display("txn: RSP (no load pending) rdata=%h", mem_rdata_i);
    tick();
    mem_rsp_valid_i = 1'b0;
    checks++; if (spurious_rsp_o !== 1'b1) begin errors++; $display("FAIL spurious_pulse: got %b want 1", spurious_rsp_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL spurious_no_rsp: got %b want 0", rsp_valid_o); end
    tick();
    checks++; if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL spurious_clear: got %b want 0", spurious_rsp_o); end
  endtask

  task automatic test_load_byte();
    set_req(1'b1, 32'h0000_1003, SZ_B, 1'b0, '0, 1'b0);
    tick();
    req_valid_i = 1'b0;
    checks++; if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h0000_1000) begin errors++; $display("FAIL lb_req: got %b/%h want 1/00001000", mem_req_valid_o, mem_addr_o); end
    checks++; if (mem_wr_o !== 1'b0 || mem_wstrb_o !== 4'b0000) begin errors++; $display("FAIL lb_strb: got %b/%b want 0/0000", mem_wr_o, mem_wstrb_o); end
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h80FF_1234;
    tick();
    mem_rsp_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rsp: got %b/%h want 1/ffffff80", rsp_valid_o, rsp_rdata_o); end
    checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL lb_req_drop: got %b want 0", mem_req_valid_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL lb_rsp_pulse: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_load_half();
    set_req(1'b1, 32'h0000_1002, SZ_H, 1'b0, '0, 1'b1);
    tick();
    req_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h80FF_1234;
    tick();
    mem_rsp_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_rsp: got %b/%h want 1/000080ff", rsp_valid_o, rsp_rdata_o); end
    set_req(1'b1, 32'h0000_1002, SZ_H, 1'b0, '0, 1'b0);
    tick();
    req_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_rsp: got %b/%h want 1/ffff80ff", rsp_valid_o, rsp_rdata_o); end
  endtask

  task automatic test_store();
    set_req(1'b1, 32'h0000_2002, SZ_H, 1'b1, 32'hABCD_1234, 1'b0);
    tick();
    req_valid_i = 1'b0;
    checks++; if (mem_req_valid_o !== 1'b1 || mem_wr_o !== 1'b1 || mem_addr_o !== 32'h0000_2000) begin errors++; $display("FAIL sh_req: got %b/%b/%h want 1/1/00002000", mem_req_valid_o, mem_wr_o, mem_addr_o); end
    checks++; if (mem_wstrb_o !== 4'b1100 || mem_wdata_o !== 32'h1234_1234) begin errors++; $display("FAIL sh_data: got %b/%h want 1100/12341234", mem_wstrb_o, mem_wdata_o); end
    set_req(1'b1, 32'h0000_2001, SZ_B, 1'b1, 32'hFFFF_FF55, 1'b0);
    tick();
    checks++; if (mem_wstrb_o !== 4'b0010 || mem_wdata_o !== 32'h5555_5555) begin errors++; $display("FAIL sb_data: got %b/%h want 0010/55555555", mem_wstrb_o, mem_wdata_o); end
    set_req(1'b1, 32'h0000_2008, SZ_W, 1'b1, 32'h0BAD_F00D, 1'b0);
    tick();
    req_valid_i = 1'b0;
    checks++; if (mem_wstrb_o !== 4'hF || mem_wdata_o !== 32'h0BAD_F00D || mem_addr_o !== 32'h0000_2008) begin errors++; $display("FAIL sw_data: got %b/%h/%h want 1111/0badf00d/00002008", mem_wstrb_o, mem_wdata_o, mem_addr_o); end
    // Stores push no metadata, so a response now has nothing to pair with.
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'hCAFE_0000;
    tick();
    mem_rsp_valid_i = 1'b0;
    checks++; if (spurious_rsp_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL st_no_push: got spur=%b rsp=%b want 1/0", spurious_rsp_o, rsp_valid_o); end
    tick();
  endtask

  task automatic test_misalign();
    set_req(1'b1, 32'h0000_3001, SZ_W, 1'b0, '0, 1'b0);
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mis_ready_pre: got %b want 1", req_ready_o); end
    tick();
    req_valid_i = 1'b0;
    checks++; if (misalign_o !== 1'b1 || misalign_addr_o !== 32'h0000_3001) begin errors++; $display("FAIL mis_pulse: got %b/%h want 1/00003001", misalign_o, misalign_addr_o); end
    checks++; if (mem_req_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL mis_no_issue: got valid=%b ready=%b want 0/1", mem_req_valid_o, req_ready_o); end
    tick();
    checks++; if (misalign_o !== 1'b0 || misalign_addr_o !== 32'h0000_3001) begin errors++; $display("FAIL mis_hold: got %b/%h want 0/00003001", misalign_o, misalign_addr_o); end
    set_req(1'b1, 32'h0000_3000, 2'b11, 1'b0, '0, 1'b0);
    tick();
    req_valid_i = 1'b0;
    checks++; if (misalign_o !== 1'b1 || misalign_addr_o !== 32'h0000_3000 || mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL mis_size: got %b/%h/%b want 1/00003000/0", misalign_o, misalign_addr_o, mem_req_valid_o); end
    set_req(1'b1, 32'h0000_3006, SZ_H, 1'b0, '0, 1'b0);
    tick();
    req_valid_i = 1'b0;
    checks++; if (misalign_o !== 1'b0 || mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h0000_3004) begin errors++; $display("FAIL mis_half_ok: got %b/%b/%h want 0/1/00003004", misalign_o, mem_req_valid_o, mem_addr_o); end
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h7F00_0000;
    tick();
    mem_rsp_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0000_7F00) begin errors++; $display("FAIL mis_half_rsp: got %b/%h want 1/00007f00", rsp_valid_o, rsp_rdata_o); end
  endtask

  task automatic test_full();
    set_req(1'b1, 32'h0000_4000, SZ_W, 1'b0, '0, 1'b0); tick();
    set_req(1'b1, 32'h0000_4001, SZ_B, 1'b0, '0, 1'b1); tick();
    set_req(1'b1, 32'h0000_4002, SZ_H, 1'b0, '0, 1'b0); tick();
    set_req(1'b1, 32'h0000_4003, SZ_B, 1'b0, '0, 1'b0); tick();
    set_req(1'b1, 32'h0000_4010, SZ_W, 1'b0, '0, 1'b0);
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready_o); end
    tick();
    checks++; if (req_ready_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL full_block: got ready=%b valid=%b want 0/0", req_ready_o, mem_req_valid_o); end
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h8899_AABB;
    tick();
    req_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h8899_AABB) begin errors++; $display("FAIL full_rsp0: got %b/%h want 1/8899aabb", rsp_valid_o, rsp_rdata_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", req_ready_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0000_00AA) begin errors++; $display("FAIL full_rsp1: got %b/%h want 1/000000aa", rsp_valid_o, rsp_rdata_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFF_8899) begin errors++; $display("FAIL full_rsp2: got %b/%h want 1/ffff8899", rsp_valid_o, rsp_rdata_o); end
    tick();
    mem_rsp_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFF_FF88) begin errors++; $display("FAIL full_rsp3: got %b/%h want 1/ffffff88", rsp_valid_o, rsp_rdata_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_req(1'b1, 32'h0000_5000, SZ_B, 1'b0, '0, 1'b0);
    tick();
    set_req(1'b1, 32'h0000_5002, SZ_H, 1'b0, '0, 1'b1);
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h0000_00F0;
    tick();
    req_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFF_FFF0) begin errors++; $display("FAIL b2b_rsp0: got %b/%h want 1/fffffff0", rsp_valid_o, rsp_rdata_o); end
    checks++; if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h0000_5000) begin errors++; $display("FAIL b2b_req1: got %b/%h want 1/00005000", mem_req_valid_o, mem_addr_o); end
    mem_rdata_i = 32'h7FFF_0000;
    tick();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0000_7FFF) begin errors++; $display("FAIL b2b_rsp1: got %b/%h want 1/00007fff", rsp_valid_o, rsp_rdata_o); end
    tick();
    mem_rsp_valid_i = 1'b0;
    checks++; if (spurious_rsp_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty: got spur=%b rsp=%b want 1/0", spurious_rsp_o, rsp_valid_o); end
    tick();
  endtask

  task automatic test_stall_reset();
    mem_req_ready_i = 1'b0;
    set_req(1'b1, 32'h0000_6004, SZ_W, 1'b0, '0, 1'b0);
    tick();
    set_req(1'b1, 32'h0000_7000, SZ_W, 1'b1, 32'h1111_2222, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_ready_o !== 1'b0 || mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h0000_6004 || mem_wr_o !== 1'b0) begin errors++; $display("FAIL stall_%0d: got ready=%b valid=%b addr=%h wr=%b want 0/1/00006004/0", i, req_ready_o, mem_req_valid_o, mem_addr_o, mem_wr_o); end
      tick();
    end
    #3 reset_n = 1'b0;
    #1;
    req_valid_i = 1'b0;
    checks++; if (mem_req_valid_o !== 1'b0 || mem_addr_o !== 32'd0 || misalign_addr_o !== 32'd0) begin errors++; $display("FAIL async_reset: got %b/%h/%h want 0/0/0", mem_req_valid_o, mem_addr_o, misalign_addr_o); end
    tick();
    reset_n = 1'b1; mem_req_ready_i = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid_i = 1'b0;
    checks++; if (spurious_rsp_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got spur=%b rsp=%b want 1/0", spurious_rsp_o, rsp_valid_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_spurious();
    test_load_byte();
    test_load_half();
    test_store();
    test_misalign();
    test_full();
    test_back_to_back();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
